// File: rtl/rom_pkg.sv
// rom_pkg: shared constants and the lookup-table contents for the rom block.
//   ROM_DEPTH_DEF / ROM_W_DEF : native table depth and word width
//   ROM_AW_DEF                : address bits needed to index the native table
//   rom_word(idx)             : table constant at idx, 0 when idx is out of range
package rom_pkg;

   localparam int unsigned ROM_DEPTH_DEF = 16;
   localparam int unsigned ROM_W_DEF     = 8;
   localparam int unsigned ROM_AW_DEF    = $clog2(ROM_DEPTH_DEF);

   typedef logic [ROM_W_DEF-1:0] rom_word_t;

   // Coefficient table, index 0 first.
   localparam rom_word_t ROM_TABLE [ROM_DEPTH_DEF] = '{
      8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
      8'h0F, 8'hED, 8'hCB, 8'hA9, 8'h87, 8'h65, 8'h43, 8'h21
   };

   function automatic rom_word_t rom_word(input int unsigned idx);
      rom_word_t word;
      word = '0;
      if (idx < ROM_DEPTH_DEF) begin
         word = ROM_TABLE[idx[ROM_AW_DEF-1:0]];
      end
      return word;
   endfunction

endpackage

// File: rtl/rom_if.sv
// rom_if: read bus of the rom block.
//   E     : read enable, active high (master -> slave)
//   addr  : word address             (master -> slave)
//   data  : registered read data     (slave -> master)
//   valid : data holds a word read on the previous edge (slave -> master)
interface rom_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) ();

   logic              E;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              valid;

   modport master (
      output E,
      output addr,
      input  data,
      input  valid
   );

   modport slave (
      input  E,
      input  addr,
      output data,
      output valid
   );

endinterface

// File: rtl/rom_table.sv
// rom_table: purely combinational address -> word lookup.
//   addr : word address (ADDR_W bits)
//   word : table word resized to DATA_W (zero-extended or truncated)
// Addresses beyond the native table depth return 0; addr is never wrapped.
module rom_table
   import rom_pkg::*;
#(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] word
);

   logic [ROM_AW_DEF-1:0] low_addr;
   logic                  in_range;
   rom_word_t             raw_word;

   // Split addr into the part that indexes the table and the part that must be zero.
   if (ADDR_W > ROM_AW_DEF) begin : g_wide_addr
      assign low_addr = addr[ROM_AW_DEF-1:0];
      assign in_range = ~|addr[ADDR_W-1:ROM_AW_DEF];
   end else if (ADDR_W == ROM_AW_DEF) begin : g_exact_addr
      assign low_addr = addr;
      assign in_range = 1'b1;
   end else begin : g_narrow_addr
      assign low_addr = {{(ROM_AW_DEF - ADDR_W){1'b0}}, addr};
      assign in_range = 1'b1;
   end

   always_comb begin
      raw_word = '0;
      if (in_range) begin
         raw_word = rom_word(32'(low_addr));
      end
   end

   if (DATA_W > ROM_W_DEF) begin : g_wide_data
      assign word = {{(DATA_W - ROM_W_DEF){1'b0}}, raw_word};
   end else if (DATA_W == ROM_W_DEF) begin : g_exact_data
      assign word = raw_word;
   end else begin : g_narrow_data
      assign word = raw_word[DATA_W-1:0];
   end

endmodule

// File: rtl/rom.sv
// rom: 16 x 8 read-only coefficient store with an enable-gated registered read.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears data and valid immediately
//   bus   : rom_if slave (E, addr in; data, valid out)
// An enabled edge loads TABLE[addr] and sets valid; a disabled edge clears both,
// so the output never holds a stale word. Outputs come straight from flops.
module rom
   import rom_pkg::*;
#(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input logic   clk,
   input logic   rst_n,
   rom_if.slave  bus
);

   logic [DATA_W-1:0] table_word;
   logic [DATA_W-1:0] data_d, data_q;
   logic              valid_d, valid_q;

   rom_table #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_table (
      .addr (bus.addr),
      .word (table_word)
   );

   // E gates the load; with E low the table output (and any unknown addr) is ignored.
   always_comb begin
      data_d  = '0;
      valid_d = 1'b0;
      if (bus.E) begin
         data_d  = table_word;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign bus.data  = data_q;
   assign bus.valid = valid_q;

endmodule

// File: tb/tb_rom.sv
// tb_rom: self-checking bench for rom. A reference table plus a one-line
// "registered lookup" rule predicts data/valid after every edge.
module tb_rom;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;

   logic clk;
   logic rst_n;

   rom_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   rom #(
      .ADDR_W (AW),
      .DATA_W (DW)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   logic [7:0] ref_tbl [16] = '{
      8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
      8'h0F, 8'hED, 8'hCB, 8'hA9, 8'h87, 8'h65, 8'h43, 8'h21
   };

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present e/addr away from the edge, let one edge pass, compare against the model.
   task automatic read_cycle(input logic e, input logic [AW-1:0] a, input string tag);
      logic [7:0] exp_data;
      logic       exp_valid;
      @(negedge clk);
      bus.E    = e;
      bus.addr = a;
      @(posedge clk);
      #1;
      exp_data  = e ? ref_tbl[a] : 8'h00;
      exp_valid = e;
      check_eq({tag, "_data"}, 32'(bus.data), 32'(exp_data));
      check_eq({tag, "_valid"}, 32'(bus.valid), 32'(exp_valid));
   endtask

   // Pulse reset between edges and confirm outputs clear without a clock.
   task automatic reset_pulse(input string tag);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq({tag, "_data"}, 32'(bus.data), 32'h0);
      check_eq({tag, "_valid"}, 32'(bus.valid), 32'h0);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n    = 1'b0;
      bus.E    = 1'b1;
      bus.addr = 4'd3;

      // Reset held across two enabled edges.
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check_eq("rst_data", 32'(bus.data), 32'h0);
         check_eq("rst_valid", 32'(bus.valid), 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Sequential reads 0..4, then disable.
      for (int i = 0; i < 5; i++) read_cycle(1'b1, AW'(i), "seq");
      read_cycle(1'b0, 4'd0, "dis");

      // Full back-to-back sweep.
      for (int i = 0; i < 16; i++) read_cycle(1'b1, AW'(i), "sweep");

      // Mid-operation reset, then reads resume on the next edge.
      read_cycle(1'b1, 4'd5, "pre_rst");
      reset_pulse("mid_rst");
      read_cycle(1'b1, 4'd9, "post_rst");
      read_cycle(1'b1, 4'd10, "post_rst2");

      // Alternating enable on a fixed address.
      for (int i = 0; i < 8; i++) read_cycle((i % 2) == 0, 4'd7, "alt");

      // Random traffic with occasional asynchronous reset pulses.
      for (int i = 0; i < 300; i++) begin
         read_cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), "rand");
         if ($urandom_range(0, 15) == 0) reset_pulse("rand_rst");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
